req_encoder_queue: RTL and testbench
====================================

Name: req_encoder_queue

Overview:
- Inverse of the 5-to-32 select decoder: collects 32 one-hot/multi-hot request lines and emits them one at a time as 5-bit encoded indices.
- Uses a valid/ready handshake; each pending request is served exactly once.
- Sits between peripheral/interrupt request lines and the processor control logic, which consumes one index per accepted transfer.
- Pending bits are latched, so requests may be single-cycle pulses.

Parameters:
- IDX_W, 5, index width. Number of request lines N = 2**IDX_W (32 at default). All widths below are stated for the default.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset_n  input  1  reset, asynchronous and active-low.
- req_in  input  32  request pulses; bit i high for one or more cycles sets pending[i].
- clear_all  input  1  synchronous flush of all pending state.
- out_ready  input  1  consumer accepts the presented index this cycle.
- out_valid  output  1  out_index is valid.
- out_index  output  5  encoded index of the request being served.
- pending  output  32  registered pending-request vector P.
- pend_count  output  6  registered popcount of P (0..32).
- dup_hit  output  1  registered one-cycle pulse, see dup_hit rules under Behaviour.

Behaviour:
- Reset (reset_n low, asynchronous): P=0, out_valid=0, out_index=0, pend_count=0, dup_hit=0, RR pointer=31. State returns to IDLE immediately, including mid-transfer.
- Accept: acc = out_valid & out_ready at a posedge. served = onehot(out_index) if acc, else 0.
- Pending update: P_next = (P & ~served) | req_in.
- clear_all: overrides the pending update and the state machine. P_next=0, out_valid_next=0, dup_hit_next=0, and req_in that cycle is discarded.
- State machine (registered outputs):
  - IDLE (out_valid=0): if P != 0, load out_index = select(P) and go to PRESENT. Otherwise stay in IDLE.
  - PRESENT (out_valid=1): out_index is held stable until acc.
  - On acc, let R = P & ~served. If R != 0, load out_index = select(R) and stay in PRESENT; this gives back-to-back throughput of one index per cycle. If R == 0, go to IDLE.
  - req_in arriving in the acc cycle is not visible to select until the next cycle.
- Latency: req_in pulse at edge N sets P at N+1; out_valid asserts at N+2 when previously IDLE.
- Simultaneous request and service of the same bit in the acc cycle: the bit is re-set in P and counts as a new event, served again later. dup_hit is not raised.
- dup_hit: pulses for one cycle when any req_in bit is high whose P bit is already 1 and is not being served that cycle. This covers requests merged into an already-pending bit.
- pend_count: popcount of P, registered alongside P. It reflects P of the same cycle.
- out_index is a member of P whenever out_valid=1 (invariant).
- select() without the optional feature: lowest set index (bit 0 has highest priority).

Optional Feature:
- Macro: REQ_ENCODER_RR_EN.
- Defined: select() is round-robin. The search starts at (ptr+1) mod 32 and wraps from 31 to 0. ptr updates to out_index on each acc and resets to 31, so the first search after reset starts at bit 0.
- Undefined: fixed lowest-index priority; no pointer register exists.

Test Plan:
- Reset then idle: req_in=0 for 10 cycles -> out_valid=0, pending=0, pend_count=0, dup_hit=0 throughout.
- Single pulse: req_in=32'h0000_0400 for 1 cycle, out_ready=1 -> out_valid high two edges later with out_index=10, low the cycle after accept; pend_count goes 1 then 0.
- Multi-hot burst: req_in=32'h8000_0011 for 1 cycle, out_ready=1 -> indices 0,4,31 on consecutive cycles with no bubble (fixed priority); with REQ_ENCODER_RR_EN after a prior grant of 4, the order is 31,0,4.
- Backpressure plus duplicate: pending bit 7, out_ready=0, pulse req_in bit 7 again -> dup_hit=1 for one cycle, out_index stays 7, pend_count stays 1. Then raise out_ready -> exactly one transfer of 7.
- Re-request on accept: bit 3 is presented, and req_in bit 3 pulses in the accept cycle -> index 3 is delivered twice and dup_hit stays 0.
- Flush and async reset: P=32'hFFFF_FFFF with clear_all=1 and req_in bit 5 in the same cycle -> next cycle pending=0, out_valid=0. Separately, drop reset_n mid-PRESENT between edges -> out_valid falls immediately.

Source files
------------

// File: rtl/req_encoder_queue_if.sv
// Handshake bundle for req_encoder_queue: request lines in, encoded index stream out.
// The master side drives requests and consumer readiness; the slave side is the queue.
interface req_encoder_queue_if #(
    parameter int IDX_W = 5
);
    localparam int N = 2 ** IDX_W;

    logic [N-1:0]     req_in;
    logic             clear_all;
    logic             out_ready;
    logic             out_valid;
    logic [IDX_W-1:0] out_index;
    logic [N-1:0]     pending;
    logic [IDX_W:0]   pend_count;
    logic             dup_hit;

    modport master (
        output req_in, clear_all, out_ready,
        input  out_valid, out_index, pending, pend_count, dup_hit
    );

    modport slave (
        input  req_in, clear_all, out_ready,
        output out_valid, out_index, pending, pend_count, dup_hit
    );
endinterface

// File: rtl/req_encoder_queue.sv
// Latches 2**IDX_W request lines and serves each pending one once as an encoded index.
// Optional macro REQ_ENCODER_RR_EN selects round-robin instead of lowest-index priority.
module req_encoder_queue #(
    parameter int IDX_W = 5
) (
    input  logic                 clock,
    input  logic                 reset_n,
    req_encoder_queue_if.slave   bus
);
    localparam int N = 2 ** IDX_W;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [N-1:0]     pending_r;
    logic [IDX_W:0]   count_r;
    logic             valid_r;
    logic [IDX_W-1:0] index_r;
    logic             dup_r;

    logic             acc_s;
    logic [N-1:0]     served_s;
    logic [N-1:0]     rem_s;
    logic [N-1:0]     next_p_s;
    logic [N-1:0]     pick_src_s;
    logic [IDX_W-1:0] pick_s;
    logic [IDX_W-1:0] next_index_s;
    logic             dup_s;

    function automatic logic [IDX_W:0] popcount(input logic [N-1:0] vec);
        logic [IDX_W:0] cnt;
        cnt = {(IDX_W+1){1'b0}};
        for (int i = 0; i < N; i++) begin
            cnt = cnt + {{IDX_W{1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

`ifdef REQ_ENCODER_RR_EN
    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] base_s;

    // Descending scan so the candidate closest after base wins.
    function automatic logic [IDX_W-1:0] pick_rr(input logic [N-1:0] vec,
                                                 input logic [IDX_W-1:0] base);
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] cand;
        idx = {IDX_W{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            cand = base + IDX_W'(i) + {{(IDX_W-1){1'b0}}, 1'b1};
            if (vec[cand]) begin
                idx = cand;
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction
`else
    function automatic logic [IDX_W-1:0] pick_low(input logic [N-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction
`endif

    // Next pending vector, duplicate detection and next presented index.
    always_comb begin
        acc_s      = valid_r & bus.out_ready;
        served_s   = acc_s ? ({{(N-1){1'b0}}, 1'b1} << index_r) : {N{1'b0}};
        rem_s      = pending_r & ~served_s;
        next_p_s   = rem_s | bus.req_in;
        dup_s      = |(bus.req_in & rem_s);
        // In IDLE acc is never true, so this selects from P; on accept, from the remainder.
        pick_src_s = acc_s ? rem_s : pending_r;
`ifdef REQ_ENCODER_RR_EN
        base_s     = acc_s ? index_r : ptr_r;
        pick_s     = pick_rr(pick_src_s, base_s);
`else
        pick_s     = pick_low(pick_src_s);
`endif
        next_state_s = state_r;
        next_index_s = index_r;
        case (state_r)
            IDLE: begin
                if (|pending_r) begin
                    next_state_s = PRESENT;
                    next_index_s = pick_s;
                end else begin
                    next_state_s = IDLE;
                end
            end
            PRESENT: begin
                if (acc_s && (|rem_s)) begin
                    next_state_s = PRESENT;
                    next_index_s = pick_s;
                end else if (acc_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = PRESENT;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State machine with registered outputs; clear_all flushes everything pending.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            pending_r <= {N{1'b0}};
            count_r   <= {(IDX_W+1){1'b0}};
            valid_r   <= 1'b0;
            index_r   <= {IDX_W{1'b0}};
            dup_r     <= 1'b0;
        end else if (bus.clear_all) begin
            state_r   <= IDLE;
            pending_r <= {N{1'b0}};
            count_r   <= {(IDX_W+1){1'b0}};
            valid_r   <= 1'b0;
            dup_r     <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            pending_r <= next_p_s;
            count_r   <= popcount(next_p_s);
            valid_r   <= (next_state_s == PRESENT);
            index_r   <= next_index_s;
            dup_r     <= dup_s;
        end
    end

`ifdef REQ_ENCODER_RR_EN
    // Round-robin pointer tracks the last accepted index.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_r <= {IDX_W{1'b1}};
        end else if (acc_s) begin
            ptr_r <= index_r;
        end else begin
            ptr_r <= ptr_r;
        end
    end
`endif

    assign bus.out_valid  = valid_r;
    assign bus.out_index  = index_r;
    assign bus.pending    = pending_r;
    assign bus.pend_count = count_r;
    assign bus.dup_hit    = dup_r;

endmodule

// File: tb/tb_req_encoder_queue.sv
// Self-checking bench for req_encoder_queue: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_req_encoder_queue;
    localparam int IDX_W = 5;
    localparam int N     = 32;

    logic clock = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    req_encoder_queue_if #(.IDX_W(IDX_W)) bus ();

    req_encoder_queue #(.IDX_W(IDX_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    // Behavioural model state
    logic [31:0] m_p     = 32'h0;
    logic        m_valid = 1'b0;
    logic [4:0]  m_idx   = 5'd0;
    logic [5:0]  m_cnt   = 6'd0;
    logic        m_dup   = 1'b0;
    int          m_ptr   = 31;

    function automatic int sel(logic [31:0] v);
`ifdef REQ_ENCODER_RR_EN
        for (int k = 1; k <= N; k++) if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
`else
        for (int k = 0; k < N; k++) if (v[k]) return k;
`endif
        return 0;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: apply the served/requested rules once per clock edge.
    always @(posedge clock or negedge reset_n) begin
        logic        acc;
        logic [31:0] served, rem, nxt;
        if (!reset_n) begin
            m_p = 32'h0; m_valid = 1'b0; m_idx = 5'd0; m_cnt = 6'd0; m_dup = 1'b0; m_ptr = 31;
        end else begin
            acc    = m_valid && bus.out_ready;
            served = acc ? (32'h1 << m_idx) : 32'h0;
            rem    = m_p & ~served;
            if (bus.clear_all) begin
                if (acc) m_ptr = m_idx;
                m_p = 32'h0; m_valid = 1'b0; m_dup = 1'b0; m_cnt = 6'd0;
            end else begin
                nxt   = rem | bus.req_in;
                m_dup = |(bus.req_in & rem);
                if (!m_valid) begin
                    if (m_p != 32'h0) begin
                        m_idx = 5'(sel(m_p));
                        m_valid = 1'b1;
                    end
                end else if (acc) begin
                    m_ptr = m_idx;
                    if (rem != 32'h0) m_idx = 5'(sel(rem));
                    else m_valid = 1'b0;
                end
                m_p   = nxt;
                m_cnt = 6'($countones(nxt));
            end
        end
    end

    // Compare DUT outputs against the model every cycle out of reset.
    always @(negedge clock) begin
        if (reset_n) begin
            chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
            chk("pending", bus.pending, m_p);
            chk("pend_count", 32'(bus.pend_count), 32'(m_cnt));
            chk("dup_hit", 32'(bus.dup_hit), 32'(m_dup));
            if (m_valid) chk("out_index", 32'(bus.out_index), 32'(m_idx));
        end
    end

    task automatic drive(logic [31:0] r, logic rdy, logic clr);
        bus.req_in    = r;
        bus.out_ready = rdy;
        bus.clear_all = clr;
        @(negedge clock);
    endtask

    logic [31:0] rnd_req;
    int          exp_order [3];

    initial begin
`ifdef REQ_ENCODER_RR_EN
        exp_order = '{31, 0, 4};
`else
        exp_order = '{0, 4, 31};
`endif
        reset_n       = 1'b1;
        bus.req_in    = 32'h0;
        bus.out_ready = 1'b0;
        bus.clear_all = 1'b0;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_index", 32'(bus.out_index), 32'h0);
        chk("rst_pending", bus.pending, 32'h0);
        chk("rst_count", 32'(bus.pend_count), 32'h0);
        chk("rst_dup", 32'(bus.dup_hit), 32'h0);
        reset_n = 1'b1;

        // Idle
        for (int i = 0; i < 10; i++) begin
            drive(32'h0, 1'b1, 1'b0);
            chk("idle_valid", 32'(bus.out_valid), 32'h0);
            chk("idle_pending", bus.pending, 32'h0);
        end

        // Single pulse of bit 10
        drive(32'h0000_0400, 1'b1, 1'b0);
        chk("sp_pending", bus.pending, 32'h0000_0400);
        chk("sp_count1", 32'(bus.pend_count), 32'd1);
        chk("sp_valid0", 32'(bus.out_valid), 32'h0);
        drive(32'h0, 1'b1, 1'b0);
        chk("sp_valid1", 32'(bus.out_valid), 32'h1);
        chk("sp_index", 32'(bus.out_index), 32'd10);
        chk("sp_model_index", 32'(m_idx), 32'd10);
        drive(32'h0, 1'b1, 1'b0);
        chk("sp_valid_after", 32'(bus.out_valid), 32'h0);
        chk("sp_count0", 32'(bus.pend_count), 32'd0);

        // Multi-hot burst, no bubble
        drive(32'h8000_0011, 1'b1, 1'b0);
        chk("mh_pending", bus.pending, 32'h8000_0011);
        for (int k = 0; k < 3; k++) begin
            drive(32'h0, 1'b1, 1'b0);
            chk("mh_valid", 32'(bus.out_valid), 32'h1);
            chk("mh_index", 32'(bus.out_index), 32'(exp_order[k]));
            chk("mh_model_index", 32'(m_idx), 32'(exp_order[k]));
        end
        drive(32'h0, 1'b1, 1'b0);
        chk("mh_done_valid", 32'(bus.out_valid), 32'h0);
        chk("mh_done_pending", bus.pending, 32'h0);

        // Backpressure plus duplicate on bit 7
        drive(32'h0000_0080, 1'b0, 1'b0);
        drive(32'h0, 1'b0, 1'b0);
        chk("dup_index", 32'(bus.out_index), 32'd7);
        drive(32'h0000_0080, 1'b0, 1'b0);
        chk("dup_hit", 32'(bus.dup_hit), 32'h1);
        chk("dup_index_held", 32'(bus.out_index), 32'd7);
        chk("dup_count", 32'(bus.pend_count), 32'd1);
        drive(32'h0, 1'b0, 1'b0);
        chk("dup_pulse_end", 32'(bus.dup_hit), 32'h0);
        chk("dup_still_valid", 32'(bus.out_valid), 32'h1);
        drive(32'h0, 1'b1, 1'b0);
        chk("dup_one_xfer_valid", 32'(bus.out_valid), 32'h0);
        chk("dup_one_xfer_pend", bus.pending, 32'h0);

        // Re-request of bit 3 in its own accept cycle
        drive(32'h0000_0008, 1'b0, 1'b0);
        drive(32'h0, 1'b0, 1'b0);
        chk("rr3_index", 32'(bus.out_index), 32'd3);
        drive(32'h0000_0008, 1'b1, 1'b0);
        chk("rr3_dup", 32'(bus.dup_hit), 32'h0);
        chk("rr3_pending", bus.pending, 32'h0000_0008);
        chk("rr3_gap", 32'(bus.out_valid), 32'h0);
        drive(32'h0, 1'b1, 1'b0);
        chk("rr3_again_valid", 32'(bus.out_valid), 32'h1);
        chk("rr3_again_index", 32'(bus.out_index), 32'd3);
        drive(32'h0, 1'b1, 1'b0);
        chk("rr3_done", bus.pending, 32'h0);

        // Flush wins over same-cycle request
        drive(32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("fl_count", 32'(bus.pend_count), 32'd32);
        drive(32'h0, 1'b0, 1'b0);
        drive(32'h0000_0020, 1'b0, 1'b1);
        chk("fl_pending", bus.pending, 32'h0);
        chk("fl_valid", 32'(bus.out_valid), 32'h0);
        drive(32'h0, 1'b0, 1'b0);
        chk("fl_discard", bus.pending, 32'h0);

        // Asynchronous reset mid-PRESENT
        drive(32'h0000_0200, 1'b0, 1'b0);
        drive(32'h0, 1'b0, 1'b0);
        chk("ar_valid_before", 32'(bus.out_valid), 32'h1);
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        chk("ar_valid_now", 32'(bus.out_valid), 32'h0);
        chk("ar_pending_now", bus.pending, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // Randomized traffic, checked by the per-cycle compare
        for (int i = 0; i < 1500; i++) begin
            rnd_req = $urandom & $urandom & $urandom;
            if ($urandom_range(0, 3) == 0) rnd_req = 32'h0;
            drive(rnd_req, 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 49) == 0));
        end
        bus.req_in = 32'h0;
        bus.clear_all = 1'b0;
        bus.out_ready = 1'b1;
        repeat (40) @(negedge clock);
        chk("drain_pending", bus.pending, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
